// File: rtl/mul_pipe.sv
// mul_pipe: pipelined RV32M/RV64M multiplier (MUL/MULH/MULHSU/MULHU) with valid/ready, stall and flush.
// No bubble compaction: in_ready_o = (!out_valid_o | out_ready_i) & !flush_i. Macro MUL_PIPE_TAG_EN adds a per-op tag.
module mul_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 2
`ifdef MUL_PIPE_TAG_EN
  ,
  parameter int TAG_W  = 5
`endif
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       op_i,
  input  logic [XLEN-1:0]  a_i,
  input  logic [XLEN-1:0]  b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  res_o
`ifdef MUL_PIPE_TAG_EN
  ,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic [TAG_W-1:0] out_tag_o
`endif
);

  localparam int EW = XLEN + 1;
  localparam int PW = 2 * XLEN;
  localparam int H  = XLEN / 2;

  logic              adv;
  logic              fire;
  logic [STAGES-1:0] v_q, v_d;
  logic [EW-1:0]     a_ext, b_ext;
  logic              hi_in;
  logic [PW-1:0]     prod_last;
  logic              hi_last;
  logic              last_v;
  logic [XLEN-1:0]   res_q;

  function automatic logic [PW-1:0] sx(input logic [EW-1:0] x);
    return {{(PW-EW){x[EW-1]}}, x};
  endfunction

  function automatic logic [XLEN-1:0] pick(input logic [PW-1:0] p, input logic hi);
    return hi ? p[PW-1:XLEN] : p[XLEN-1:0];
  endfunction

  assign adv        = !v_q[STAGES-1] | out_ready_i;
  assign in_ready_o = adv & !flush_i;
  assign fire       = in_valid_i & in_ready_o;

  always_comb begin
    a_ext = {1'b0, a_i};
    b_ext = {1'b0, b_i};
    if (op_i == 2'b01) begin
      a_ext = {a_i[XLEN-1], a_i};
      b_ext = {b_i[XLEN-1], b_i};
    end else if (op_i == 2'b10) begin
      a_ext = {a_i[XLEN-1], a_i};
    end
  end

  assign hi_in = (op_i != 2'b00);

  always_comb begin
    v_d = v_q;
    if (flush_i) begin
      v_d = '0;
    end else if (adv) begin
      v_d[0] = fire;
      for (int k = 1; k < STAGES; k++) v_d[k] = v_q[k-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) v_q <= '0;
    else       v_q <= v_d;
  end

  if (STAGES == 1) begin : g_one
    assign prod_last = sx(a_ext) * sx(b_ext);
    assign hi_last   = hi_in;
    assign last_v    = fire;
  end else begin : g_multi
    logic [EW-1:0] a0_q, b0_q;
    logic          hi0_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        a0_q  <= '0;
        b0_q  <= '0;
        hi0_q <= 1'b0;
      end else if (adv) begin
        a0_q  <= a_ext;
        b0_q  <= b_ext;
        hi0_q <= hi_in;
      end
    end

    assign last_v = v_q[STAGES-2];

    if (STAGES == 2) begin : g_two
      assign prod_last = sx(a0_q) * sx(b0_q);
      assign hi_last   = hi0_q;
    end else begin : g_deep
      localparam int BW = EW - H;
      localparam int ND = STAGES - 2;

      logic [PW-1:0] pl_q [ND];
      logic [PW-1:0] ph_q [ND];
      logic [ND-1:0] hp_q;
      logic [PW-1:0] pl_d, ph_d;
      logic [BW-1:0] b0_hi;

      // b = b_hi * 2^H + b_lo; b_lo is unsigned, b_hi keeps the sign of the extended operand
      assign b0_hi = b0_q[EW-1:H];
      assign pl_d  = sx(a0_q) * {{(PW-H){1'b0}}, b0_q[H-1:0]};
      assign ph_d  = (sx(a0_q) * {{(PW-BW){b0_hi[BW-1]}}, b0_hi}) << H;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          for (int k = 0; k < ND; k++) begin
            pl_q[k] <= '0;
            ph_q[k] <= '0;
          end
          hp_q <= '0;
        end else if (adv) begin
          pl_q[0] <= pl_d;
          ph_q[0] <= ph_d;
          hp_q[0] <= hi0_q;
          for (int k = 1; k < ND; k++) begin
            pl_q[k] <= pl_q[k-1];
            ph_q[k] <= ph_q[k-1];
            hp_q[k] <= hp_q[k-1];
          end
        end
      end

      assign prod_last = pl_q[ND-1] + ph_q[ND-1];
      assign hi_last   = hp_q[ND-1];
    end
  end

  // res only reloads when a live op enters the last stage, so it keeps the last result across bubbles
  always_ff @(posedge clk_i) begin
    if (rst_i)               res_q <= '0;
    else if (adv && last_v)  res_q <= pick(prod_last, hi_last);
  end

  assign res_o       = res_q;
  assign out_valid_o = v_q[STAGES-1];

`ifdef MUL_PIPE_TAG_EN
  logic [TAG_W-1:0] tag_q [STAGES];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < STAGES; k++) tag_q[k] <= '0;
    end else if (adv) begin
      tag_q[0] <= in_tag_i;
      for (int k = 1; k < STAGES; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  assign out_tag_o = tag_q[STAGES-1];
`endif

endmodule

// File: tb/tb_mul_pipe.sv
// Scoreboard bench for mul_pipe: XLEN=32/STAGES=2 and XLEN=64/STAGES=4 instances, directed vectors.
module tb_mul_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0, res;

  logic        in_valid64 = 1'b0, out_ready64 = 1'b1;
  logic        in_ready64, out_valid64;
  logic [1:0]  op64 = 2'b00;
  logic [63:0] a64 = '0, b64 = '0, res64;

`ifdef MUL_PIPE_TAG_EN
  logic [4:0] tag32 = '0, otag32, tag64 = '0, otag64;
`endif

  int nchk = 0;
  int nerr = 0;
  int nresp32 = 0;
  int run_len = 0, max_run = 0;
  logic [31:0] q32[$];
  logic [63:0] q64[$];

  always #5 clk = ~clk;

  mul_pipe #(.XLEN(32), .STAGES(2)) u32 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .op_i(op), .a_i(a), .b_i(b),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .res_o(res)
`ifdef MUL_PIPE_TAG_EN
    , .in_tag_i(tag32), .out_tag_o(otag32)
`endif
  );

  mul_pipe #(.XLEN(64), .STAGES(4)) u64 (
    .clk_i(clk), .rst_i(rst), .flush_i(1'b0),
    .in_valid_i(in_valid64), .in_ready_o(in_ready64), .op_i(op64), .a_i(a64), .b_i(b64),
    .out_valid_o(out_valid64), .out_ready_i(out_ready64), .res_o(res64)
`ifdef MUL_PIPE_TAG_EN
    , .in_tag_i(tag64), .out_tag_o(otag64)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst && out_valid && out_ready) begin
      nresp32++;
      if (q32.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL resp32_unexpected got=%h exp=none", res);
      end else begin
        e = q32.pop_front();
        chk("resp32", {32'b0, res}, {32'b0, e});
      end
    end
    run_len = out_valid ? run_len + 1 : 0;
    if (run_len > max_run) max_run = run_len;
  end

  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst && out_valid64 && out_ready64) begin
      if (q64.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL resp64_unexpected got=%h exp=none", res64);
      end else begin
        e = q64.pop_front();
        chk("resp64", res64, e);
      end
    end
  end

  task automatic issue32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] e);
    int n = 0;
    in_valid = 1'b1; op = o; a = x; b = y;
    #1;
    while (!in_ready && n < 50) begin @(posedge clk); #2; n++; end
    if (!in_ready) begin
      nchk++; nerr++;
      $display("FAIL issue32_timeout got=in_ready_low exp=accept");
    end else begin
      q32.push_back(e);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic issue64(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y,
                         input logic [63:0] e);
    int n = 0;
    in_valid64 = 1'b1; op64 = o; a64 = x; b64 = y;
    #1;
    while (!in_ready64 && n < 50) begin @(posedge clk); #2; n++; end
    if (!in_ready64) begin
      nchk++; nerr++;
      $display("FAIL issue64_timeout got=in_ready_low exp=accept");
    end else begin
      q64.push_back(e);
      @(posedge clk); #1;
    end
    in_valid64 = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((q32.size() != 0 || q64.size() != 0) && n < 60) begin @(posedge clk); #1; n++; end
    chk(nm, 64'(q32.size() + q64.size()), 64'd0);
  endtask

  initial begin
    int r0;
    logic [31:0] held;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_res", {32'b0, res}, 64'd0);
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    chk("rst_out_valid64", {63'b0, out_valid64}, 64'd0);
    chk("rst_res64", res64, 64'd0);
    @(posedge clk); #1;

    // MUL latency: accepted at edge N, valid after edge N+1
    in_valid = 1'b1; op = 2'b00; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    q32.push_back(32'h00000001);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk) chk("mul_lat_early", {63'b0, out_valid}, 64'd0);
    @(posedge clk);
    @(negedge clk) chk("mul_lat_valid", {63'b0, out_valid}, 64'd1);
    @(posedge clk); #1;

    issue32(2'b01, 32'h80000000, 32'h80000000, 32'h40000000);
    issue32(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
    issue32(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    issue32(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    drain("drain_ops");

    // Back-to-back stream: i*(i+3)
    begin
      logic [31:0] exp_s [8] = '{32'd0, 32'd4, 32'd10, 32'd18, 32'd28, 32'd40, 32'd54, 32'd70};
      repeat (3) @(posedge clk);
      #1 max_run = 0;
      for (int i = 0; i < 8; i++) issue32(2'b00, 32'(i), 32'(i + 3), exp_s[i]);
      drain("drain_stream");
      repeat (2) @(posedge clk);
      chk("stream_run", 64'(max_run), 64'd8);
    end

    // Stall with out_ready low for 5 cycles
    #1 out_ready = 1'b0;
    r0 = nresp32;
    issue32(2'b00, 32'd10, 32'd20, 32'd200);
    issue32(2'b00, 32'h12345678, 32'd9, 32'hA3D70A38);
    in_valid = 1'b1; op = 2'b01; a = 32'hFFFFFFFE; b = 32'd3;
    @(negedge clk);
    held = res;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", {63'b0, in_ready}, 64'd0);
      chk("stall_out_valid", {63'b0, out_valid}, 64'd1);
      chk("stall_res_hold", {32'b0, res}, {32'b0, held});
    end
    chk("stall_res_val", {32'b0, res}, 64'd200);
    @(posedge clk); #1;
    out_ready = 1'b1;
    q32.push_back(32'hFFFFFFFF);
    #1 chk("stall_release_ready", {63'b0, in_ready}, 64'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    drain("drain_stall");
    chk("stall_resp_count", 64'(nresp32 - r0), 64'd3);

    // Flush with 2 ops in flight; request in the flush cycle is dropped
    out_ready = 1'b0;
    issue32(2'b00, 32'd3, 32'd3, 32'd9);
    issue32(2'b00, 32'd4, 32'd4, 32'd16);
    in_valid = 1'b1; op = 2'b00; a = 32'd5; b = 32'd5;
    flush = 1'b1;
    #1 chk("flush_in_ready", {63'b0, in_ready}, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    q32.delete();
    r0 = nresp32;
    @(negedge clk) chk("flush_out_valid", {63'b0, out_valid}, 64'd0);
    repeat (4) @(posedge clk);
    chk("flush_no_stale", 64'(nresp32 - r0), 64'd0);
    #1 issue32(2'b11, 32'd2, 32'd3, 32'd0);
    drain("drain_flush");

    // Reset mid-stream
    issue32(2'b00, 32'd7, 32'd6, 32'd42);
    issue32(2'b00, 32'd5, 32'd5, 32'd25);
    rst = 1'b1;
    @(posedge clk); #1;
    q32.delete();
    @(negedge clk);
    chk("rst_mid_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_mid_res", {32'b0, res}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk) chk("rst_mid_in_ready", {63'b0, in_ready}, 64'd1);
    issue32(2'b00, 32'd11, 32'd11, 32'd121);
    drain("drain_after_rst");

    // XLEN=64, STAGES=4: 3-cycle latency MULH
    @(posedge clk); #1;
    in_valid64 = 1'b1; op64 = 2'b01; a64 = 64'h8000000000000000; b64 = 64'd2;
    q64.push_back(64'hFFFFFFFFFFFFFFFF);
    @(posedge clk); #1 in_valid64 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk) chk("lat64_early", {63'b0, out_valid64}, 64'd0);
      @(posedge clk); #1;
    end
    @(negedge clk) chk("lat64_valid", {63'b0, out_valid64}, 64'd1);
    @(posedge clk); #1;
    issue64(2'b11, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFE);
    issue64(2'b00, 64'h0000000100000000, 64'h0000000100000000, 64'h0);
    issue64(2'b10, 64'hFFFFFFFFFFFFFFFF, 64'd2, 64'hFFFFFFFFFFFFFFFF);
    issue64(2'b00, 64'h0000000123456789, 64'h10001, 64'h000123468ACE6789);
    drain("drain64");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
